// File: rtl/seq_pkg.sv
// Shared definitions for the 0110 sync-sequence link: state encoding,
// sync preamble constants and counter sizing helper.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam int              SYNC_W     = 4;
  localparam logic [SYNC_W-1:0] SYNC_PRE = 4'b0110;
  localparam logic            IDLE_LEVEL = 1'b1;

  // Bit-counter width able to index the longer of two fields (minimum 1).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seq_shift.sv
// Payload PISO shift register with bit counter and last-bit flag.
// SEQ_TX_PARITY_EN adds a parity output captured at load time.
module seq_shift
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  output logic              nxt_bit,
  output logic              last
`ifdef SEQ_TX_PARITY_EN
  ,
  output logic              par
`endif
);

  localparam int CNT_W = cnt_width(DATA_W, 1);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign last    = (cnt_q == CNT_W'(DATA_W - 1));
  // The MSB of the next register value is the bit the line will carry next.
  assign nxt_bit = sh_d[DATA_W-1];

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = din;
      cnt_d = '0;
    end else if (shift) begin
      sh_d  = sh_q << 1;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SEQ_TX_PARITY_EN
  logic par_q, par_d;

  // Parity is taken from the parallel word, before any shifting.
  always_comb begin
    par_d = par_q;
    if (load) par_d = ^din;
  end

  always_ff @(posedge clk) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign par = par_q;
`endif

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: 0110 preamble, MSB-first payload, one idle gap bit.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_tx
  import seq_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               PRE_W  = SYNC_W,
  parameter logic [PRE_W-1:0] PRE    = SYNC_PRE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              z,
  output logic              frame,
  output logic              done
);

  localparam int CNT_W = cnt_width(PRE_W, DATA_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept, shift_en, sh_nxt, sh_last;
`ifdef SEQ_TX_PARITY_EN
  logic             sh_par;
`endif

  function automatic logic pre_bit(input logic [CNT_W-1:0] idx);
    pre_bit = 1'b0;
    for (int i = 0; i < PRE_W; i++) begin
      if (idx == CNT_W'(PRE_W - 1 - i)) pre_bit = PRE[i];
    end
  endfunction

  seq_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .din     (din),
    .shift   (shift_en),
    .nxt_bit (sh_nxt),
    .last    (sh_last)
`ifdef SEQ_TX_PARITY_EN
    ,
    .par     (sh_par)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load && ready_q) begin
          accept  = 1'b1;
          state_d = ST_PRE;
          cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (cnt_q == CNT_W'(PRE_W - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (sh_last) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_GAP;
`endif
          cnt_d = '0;
        end
      end
      ST_PAR:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line and
  // flags line up with the state they describe.
  always_comb begin
    z_d = IDLE_LEVEL;
    case (state_d)
      ST_PRE:  z_d = pre_bit(cnt_d);
      ST_DATA: z_d = sh_nxt;
`ifdef SEQ_TX_PARITY_EN
      ST_PAR:  z_d = sh_par;
`endif
      default: z_d = IDLE_LEVEL;
    endcase
    frame_d = (state_d == ST_PRE) || (state_d == ST_DATA) || (state_d == ST_PAR);
    done_d  = (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= IDLE_LEVEL;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign z     = z_q;
  assign frame = frame_q;
  assign done  = done_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: directed vector table, corner-case sequences and a
// randomized run against a frame-queue reference model.
module tb_seq_tx;

  localparam int DATA_W = 8;
  localparam int PRE_W  = 4;
`ifdef SEQ_TX_PARITY_EN
  localparam int PAR_W  = 1;
`else
  localparam int PAR_W  = 0;
`endif
  localparam int FL = PRE_W + DATA_W + PAR_W;
  // Output vector layout: {z, frame, done, ready}
  localparam logic [3:0] IDLE_V = 4'b1001;
  localparam logic [3:0] GAP_V  = 4'b1010;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [DATA_W-1:0] din;
  logic              ready, z, frame, done;

  always #5 clk = ~clk;

  seq_tx #(
    .DATA_W (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .ready (ready),
    .z     (z),
    .frame (frame),
    .done  (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]       mq[$];
  logic [3:0]       mexp  = IDLE_V;
  logic [PRE_W-1:0] pre_v = 4'b0110;

  typedef struct {
    logic              r;
    logic              l;
    logic [DATA_W-1:0] d;
    logic [3:0]        e;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {z,frame,done,ready}=%b want %b", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] d);
    for (int i = PRE_W - 1; i >= 0; i--) mq.push_back({pre_v[i], 3'b100});
    for (int i = DATA_W - 1; i >= 0; i--) mq.push_back({d[i], 3'b100});
`ifdef SEQ_TX_PARITY_EN
    mq.push_back({^d, 3'b100});
`endif
    mq.push_back(GAP_V);
  endtask

  task automatic step(input logic r, input logic l, input logic [DATA_W-1:0] d,
                      output logic [3:0] act, output logic [3:0] mdl);
    reset = r;
    load  = l;
    din   = d;
    @(posedge clk);
    #1;
    if (!r) begin
      mq.delete();
      mexp = IDLE_V;
    end else begin
      if (mexp[0] && l) push_frame(d);
      mexp = (mq.size() != 0) ? mq.pop_front() : IDLE_V;
    end
    act = {z, frame, done, ready};
    mdl = mexp;
  endtask

  task automatic add(input logic r, input logic l, input logic [DATA_W-1:0] d,
                     input logic [3:0] e);
    vec_t v;
    v.r = r; v.l = l; v.d = d; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0]        act, mdl;
    logic [11:0]       fbits;
    logic [DATA_W-1:0] a5;
    logic              bz, seen_done;

    reset = 1'b0;
    load  = 1'b0;
    din   = '0;

    // Directed table: reset, idle hold, A5 frame with ignored mid-frame and gap loads
    a5    = 8'hA5;
    fbits = {pre_v, a5};
    add(0, 0, 8'h00, IDLE_V);
    add(0, 0, 8'h00, IDLE_V);
    for (int i = 0; i < 10; i++) add(1, 0, 8'h00, IDLE_V);
    for (int j = 0; j < FL; j++) begin
      bz = (j < 12) ? fbits[11 - j] : ^a5;
      if (j == 0) add(1, 1, a5, {bz, 3'b100});
      else        add(1, (j == 3), 8'h3C, {bz, 3'b100});
    end
    add(1, 0, 8'h3C, GAP_V);
    add(1, 1, 8'h3C, IDLE_V);
    for (int i = 0; i < 3; i++) add(1, 0, 8'h3C, IDLE_V);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, tbl[i].d, act, mdl);
      chk($sformatf("tbl[%0d]", i), act, tbl[i].e);
    end

    // Back-to-back with load held: 00 frame, then FF frame
    step(1, 1, 8'h00, act, mdl);
    chk("b2b_accept", act, mdl);
    for (int i = 1; i <= 2 * FL + 3; i++) begin
      step(1, 1, 8'hFF, act, mdl);
      chk($sformatf("b2b[%0d]", i), act, mdl);
      if (i == FL)     chk("b2b_gap", act, GAP_V);
      if (i == FL + 1) chk("b2b_idle", act, IDLE_V);
      if (i == FL + 2) chk("b2b_restart", act, {pre_v[PRE_W-1], 3'b100});
      if (i == FL + 2 + PRE_W)        chk("b2b_ones_first", act, 4'b1100);
      if (i == FL + 1 + PRE_W + DATA_W) chk("b2b_ones_last", act, 4'b1100);
    end
    step(1, 0, 8'h00, act, mdl);
    chk("b2b_tail", act, mdl);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00, act, mdl);
      chk("b2b_settle", act, mdl);
    end

    // Reset asserted mid-payload: abandon frame, no done pulse
    seen_done = 1'b0;
    step(1, 1, 8'h5A, act, mdl);
    chk("rst_accept", act, mdl);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, DATA_W'($urandom), act, mdl);
      chk($sformatf("rst_pre[%0d]", i), act, mdl);
    end
    step(0, 0, 8'h00, act, mdl);
    chk("rst_mid", act, IDLE_V);
    seen_done = act[1];
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'h00, act, mdl);
      chk("rst_after", act, mdl);
      seen_done = seen_done | act[1];
    end
    chk("rst_no_done", {3'b000, seen_done}, 4'b0000);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic r, l;
      r = ($urandom_range(0, 199) != 0);
      l = ($urandom_range(0, 2) == 0);
      step(r, l, DATA_W'($urandom), act, mdl);
      chk($sformatf("rand[%0d]", i), act, mdl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
